// File: rtl/stack_op_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stack_op_ctrl_pkg
// Brief   : Opcodes, FSM state encoding and default sizes shared by the
//           stack command sequencer and its ALU.
// Revision: 1.0 - initial release
// ============================================================================
package stack_op_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_AW    = 4;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP_A  = 3'd1,
    ST_POP_B  = 3'd2,
    ST_PUSH_1 = 3'd3,
    ST_PUSH_2 = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/stack_op_ctrl_alu.sv
`default_nettype none
// ============================================================================
// Module  : stack_op_ctrl_alu
// Brief   : Combinational ADD/SUB/AND of the two popped operands (B op A),
//           modulo 2^WIDTH, no flags. Other opcodes give zero.
// Revision: 1.0 - initial release
// ============================================================================
module stack_op_ctrl_alu
  import stack_op_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  // Select the arithmetic result; B is the deeper entry, so SUB is B - A
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = b_i + a_i;
      OP_SUB:  y_o = b_i - a_i;
      OP_AND:  y_o = b_i & a_i;
      default: y_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stack_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : stack_op_ctrl
// Brief   : Micro-sequencer in front of a LIFO stack. Accepts stack-machine
//           commands, expands them into single-cycle pops/pushes and returns
//           one response per accepted command.
// Revision: 1.0 - initial release
// ============================================================================
module stack_op_ctrl
  import stack_op_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_imm_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_err_o,
  output logic             stk_en_o,
  output logic             stk_mode_o,
  output logic [WIDTH-1:0] stk_wdata_o,
  input  logic [WIDTH-1:0] stk_rdata_i,
  input  logic             stk_empty_i,
  input  logic             stk_full_i,
  input  logic [AW-1:0]    stk_amount_i
);

  localparam logic [AW-1:0] c_one   = AW'(1);
  localparam logic [AW-1:0] c_two   = AW'(2);
  localparam logic [AW-1:0] c_depth = AW'(DEPTH);
  localparam logic [AW-1:0] c_dm1   = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             w_legal;
  logic [WIDTH-1:0] w_alu_y;

  // B is the value on the stack read port during POP_B, A was captured earlier
  stack_op_ctrl_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i (op_q),
    .b_i  (stk_rdata_i),
    .a_i  (a_q),
    .y_o  (w_alu_y)
  );

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign stk_en_o    = (state_q == ST_POP_A) || (state_q == ST_POP_B) ||
                       (state_q == ST_PUSH_1) || (state_q == ST_PUSH_2);
  assign stk_mode_o  = (state_q == ST_PUSH_1) || (state_q == ST_PUSH_2);
  assign stk_wdata_o = wdata_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

  // Legality of the offered command against the current entry count; the
  // empty/full flags double-check the count so the stack is never misused
  always_comb begin
    w_legal = 1'b0;
    case (cmd_op_i)
      OP_NOP:  w_legal = 1'b1;
      OP_PUSH: w_legal = (stk_amount_i < c_depth) && !stk_full_i;
      OP_POP:  w_legal = (stk_amount_i >= c_one) && !stk_empty_i;
      OP_DUP:  w_legal = (stk_amount_i >= c_one) && (stk_amount_i <= c_dm1) &&
                         !stk_empty_i && !stk_full_i;
      default: w_legal = (stk_amount_i >= c_two) && !stk_empty_i;
    endcase
  end

  // Next-state and datapath register updates for the command sequence
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          op_d = cmd_op_i;
          if (!w_legal) begin
            state_d    = ST_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else if (cmd_op_i == OP_NOP) begin
            state_d = ST_RESP;
          end else if (cmd_op_i == OP_PUSH) begin
            state_d = ST_PUSH_1;
            wdata_d = cmd_imm_i;
          end else begin
            state_d = ST_POP_A;
          end
        end
      end
      ST_POP_A: begin
        a_d = stk_rdata_i;
        case (op_q)
          OP_POP: begin
            state_d    = ST_RESP;
            rsp_data_d = stk_rdata_i;
          end
          OP_DUP: begin
            state_d = ST_PUSH_1;
            wdata_d = stk_rdata_i;
          end
          default: state_d = ST_POP_B;
        endcase
      end
      ST_POP_B: begin
        b_d     = stk_rdata_i;
        state_d = ST_PUSH_1;
        wdata_d = (op_q == OP_SWAP) ? a_q : w_alu_y;
      end
      ST_PUSH_1: begin
        if (op_q == OP_DUP) begin
          state_d = ST_PUSH_2;
        end else if (op_q == OP_SWAP) begin
          state_d = ST_PUSH_2;
          wdata_d = b_q;
        end else begin
          state_d    = ST_RESP;
          rsp_data_d = (op_q == OP_PUSH) ? '0 : wdata_q;
        end
      end
      ST_PUSH_2: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d    = ST_IDLE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset abandons any command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      a_q        <= '0;
      b_q        <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_stack_op_ctrl
// Brief   : Self-checking bench for stack_op_ctrl with a behavioural 8-deep
//           stack attached; responses are checked against a scoreboard queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stack_op_ctrl;
  import stack_op_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid_i, cmd_ready_o, rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [2:0]  cmd_op_i;
  logic [15:0] cmd_imm_i, rsp_data_o, stk_wdata_o, stk_rdata_i;
  logic        stk_en_o, stk_mode_o, stk_empty_i, stk_full_i;
  logic [3:0]  stk_amount_i;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          en_seen = 0;
  int          viol    = 0;
  int          en_snap;

  logic [15:0] mem [8];
  logic [3:0]  cnt;
  logic [3:0]  top_idx;

  always #5 clk = ~clk;

  stack_op_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_imm_i    (cmd_imm_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_err_o    (rsp_err_o),
    .stk_en_o     (stk_en_o),
    .stk_mode_o   (stk_mode_o),
    .stk_wdata_o  (stk_wdata_o),
    .stk_rdata_i  (stk_rdata_i),
    .stk_empty_i  (stk_empty_i),
    .stk_full_i   (stk_full_i),
    .stk_amount_i (stk_amount_i)
  );

  // Behavioural LIFO sharing the controller's reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= 4'd0;
    else if (stk_en_o) begin
      if (stk_mode_o) begin
        if (cnt < 4'd8) cnt <= cnt + 4'd1;
      end else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

  // Stack storage write
  always_ff @(posedge clk) begin
    if (rst && stk_en_o && stk_mode_o && cnt < 4'd8) mem[cnt[2:0]] <= stk_wdata_o;
  end

  assign top_idx      = cnt - 4'd1;
  assign stk_rdata_i  = (cnt == 4'd0) ? 16'h0000 : mem[top_idx[2:0]];
  assign stk_empty_i  = (cnt == 4'd0);
  assign stk_full_i   = (cnt == 4'd8);
  assign stk_amount_i = cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stack-access counter and misuse detector
  always @(posedge clk) begin
    if (rst && stk_en_o) en_seen++;
    if (rst && stk_en_o && ((!stk_mode_o && stk_empty_i) || (stk_mode_o && stk_full_i))) viol++;
  end

  // Response monitor: compare each handshaken response with the scoreboard
  always @(negedge clk) begin
    if (rst && rsp_valid_o && rsp_ready_i) begin
      if (sb_q.size() == 0) check_eq("sb_underrun", 32'd1, 32'd0);
      else begin
        mon_e = sb_q.pop_front();
        check_eq("rsp_data", rsp_data_o, mon_e.data);
        check_eq("rsp_err", rsp_err_o, mon_e.err);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] imm, input logic [15:0] ed,
                      input logic ee, input int lat, input bit hold);
    exp_t e;
    int   n;
    e.data = ed;
    e.err  = ee;
    rsp_ready_i = !hold;
    @(negedge clk);
    n = 0;
    while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready_o) begin check_eq("cmd_ready_timeout", 32'd0, 32'd1); return; end
    sb_q.push_back(e);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_imm_i   = imm;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    n = 1;
    while (!rsp_valid_o && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp_valid_o) begin
      check_eq("rsp_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_back());
      return;
    end
    check_eq("latency", n, lat);
    if (hold) begin
      repeat (5) begin
        @(posedge clk); #1;
        check_eq("hold_valid", rsp_valid_o, 32'd1);
        check_eq("hold_cmd_ready", cmd_ready_o, 32'd0);
        check_eq("hold_data", rsp_data_o, ed);
        check_eq("hold_err", rsp_err_o, ee);
      end
      rsp_ready_i = 1'b1;
    end
    @(posedge clk); #1;
    check_eq("rsp_valid_clr", rsp_valid_o, 32'd0);
    check_eq("rsp_data_clr", rsp_data_o, 32'd0);
  endtask

  initial begin
    cmd_valid_i = 1'b0;
    cmd_op_i    = OP_NOP;
    cmd_imm_i   = 16'h0;
    rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", cmd_ready_o, 32'd1);
    check_eq("rst_rsp_valid", rsp_valid_o, 32'd0);
    check_eq("rst_stk_en", stk_en_o, 32'd0);
    check_eq("rst_rsp_data", rsp_data_o, 32'd0);
    check_eq("rst_rsp_err", rsp_err_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: add
    send(OP_PUSH, 16'h1234, 16'h0, 1'b0, 2, 1'b0);
    send(OP_PUSH, 16'h0001, 16'h0, 1'b0, 2, 1'b0);
    send(OP_ADD,  16'h0,    16'h1235, 1'b0, 4, 1'b0);
    check_eq("t1_amount", stk_amount_i, 32'd1);
    send(OP_POP,  16'h0,    16'h1235, 1'b0, 2, 1'b0);

    // 2: subtract both ways, and bitwise and
    send(OP_PUSH, 16'd5, 16'h0, 1'b0, 2, 1'b0);
    send(OP_PUSH, 16'd3, 16'h0, 1'b0, 2, 1'b0);
    send(OP_SUB,  16'h0, 16'h0002, 1'b0, 4, 1'b0);
    send(OP_POP,  16'h0, 16'h0002, 1'b0, 2, 1'b0);
    send(OP_PUSH, 16'd3, 16'h0, 1'b0, 2, 1'b0);
    send(OP_PUSH, 16'd5, 16'h0, 1'b0, 2, 1'b0);
    send(OP_SUB,  16'h0, 16'hFFFE, 1'b0, 4, 1'b0);
    send(OP_POP,  16'h0, 16'hFFFE, 1'b0, 2, 1'b0);
    send(OP_PUSH, 16'hF0F0, 16'h0, 1'b0, 2, 1'b0);
    send(OP_PUSH, 16'h3C3C, 16'h0, 1'b0, 2, 1'b0);
    send(OP_AND,  16'h0, 16'h3030, 1'b0, 4, 1'b0);
    send(OP_POP,  16'h0, 16'h3030, 1'b0, 2, 1'b0);

    // 3: swap
    send(OP_PUSH, 16'hAAAA, 16'h0, 1'b0, 2, 1'b0);
    send(OP_PUSH, 16'hBBBB, 16'h0, 1'b0, 2, 1'b0);
    send(OP_SWAP, 16'h0, 16'h0, 1'b0, 5, 1'b0);
    send(OP_POP,  16'h0, 16'hAAAA, 1'b0, 2, 1'b0);
    send(OP_POP,  16'h0, 16'hBBBB, 1'b0, 2, 1'b0);
    check_eq("t3_amount", stk_amount_i, 32'd0);

    // 4: underflow, overflow, boundaries
    en_snap = en_seen;
    send(OP_POP, 16'h0, 16'h0, 1'b1, 1, 1'b0);
    send(OP_ADD, 16'h0, 16'h0, 1'b1, 1, 1'b0);
    send(OP_NOP, 16'h0, 16'h0, 1'b0, 1, 1'b0);
    check_eq("t4_no_stk_en", en_seen - en_snap, 32'd0);
    for (int i = 0; i < 8; i++) send(OP_PUSH, 16'h0100 + 16'(i), 16'h0, 1'b0, 2, 1'b0);
    send(OP_PUSH, 16'hDEAD, 16'h0, 1'b1, 1, 1'b0);
    check_eq("t4_amount_full", stk_amount_i, 32'd8);
    send(OP_DUP, 16'h0, 16'h0, 1'b1, 1, 1'b0);
    check_eq("t4_amount_dup", stk_amount_i, 32'd8);
    for (int i = 0; i < 8; i++) send(OP_POP, 16'h0, 16'h0107 - 16'(i), 1'b0, 2, 1'b0);

    // 5: dup with back-pressure
    send(OP_PUSH, 16'd7, 16'h0, 1'b0, 2, 1'b0);
    send(OP_DUP,  16'h0, 16'h0, 1'b0, 4, 1'b1);
    send(OP_POP,  16'h0, 16'h0007, 1'b0, 2, 1'b0);
    send(OP_POP,  16'h0, 16'h0007, 1'b0, 2, 1'b0);

    // 6: reset in the middle of a swap
    send(OP_PUSH, 16'h0011, 16'h0, 1'b0, 2, 1'b0);
    send(OP_PUSH, 16'h0022, 16'h0, 1'b0, 2, 1'b0);
    @(negedge clk);
    check_eq("t6_ready", cmd_ready_o, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = OP_SWAP;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_eq("t6_rsp_valid", rsp_valid_o, 32'd0);
    check_eq("t6_cmd_ready", cmd_ready_o, 32'd1);
    check_eq("t6_stk_en", stk_en_o, 32'd0);
    check_eq("t6_rsp_data", rsp_data_o, 32'd0);
    check_eq("t6_rsp_err", rsp_err_o, 32'd0);
    check_eq("t6_amount", stk_amount_i, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send(OP_PUSH, 16'h0001, 16'h0, 1'b0, 2, 1'b0);
    check_eq("t6_amount_after", stk_amount_i, 32'd1);

    check_eq("stk_invariant", viol, 32'd0);
    check_eq("sb_leftover", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
